// File: rtl/hc_reduce.sv
// -----------------------------------------------------------------------------
// hc_reduce
//   Reduction stage that sits right after the per-lane hC multiplier. For every
//   (h,p) lane it adds the N_TILE products of a tile with a pipelined FP16
//   adder tree, then accumulates the tile sums over N_TILES consecutive tiles.
//   One y vector is produced per token.
//
// Ports
//   clk      in   clock
//   rstn     in   synchronous active-low reset
//   valid_i  in   tile valid, taken only while ready_o=1
//   ready_o  out  block can accept a tile
//   hC_i     in   products, element ((h*P_TILE+p)*N_TILE+n)
//   y_o      out  token result, element (h*P_TILE+p)
//   valid_o  out  one-cycle pulse marking y_o as new
//
// Also contains fp16_add_wrapper, a fixed-latency FP16 adder with a
// valid side-band and no reset.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// fp16_add_wrapper
//   result = a + b (IEEE half precision, round to nearest even), delivered LAT
//   cycles after valid_in. The pipeline has no reset, so valid_out may show
//   stale values right after power-up; consumers must filter by context.
//
// Ports
//   clk        in   clock
//   valid_in   in   operands valid
//   a, b       in   FP16 operands
//   valid_out  out  result valid, LAT cycles after valid_in
//   result     out  FP16 sum
// -----------------------------------------------------------------------------
module fp16_add_wrapper #(
  parameter int LAT = 11
) (
  input  logic        clk,
  input  logic        valid_in,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        valid_out,
  output logic [15:0] result
);

  logic [15:0] res_pipe [LAT];
  logic        vld_pipe [LAT];

  // Combinational half-precision add. Operands are ordered by magnitude so the
  // subtraction never goes negative; three extra bits (guard, round, sticky)
  // carry the shifted-out part of the smaller operand into the rounding step.
  function automatic logic [15:0] fp16_add(input logic [15:0] op_a, input logic [15:0] op_b);
    logic [15:0] x, y, res;
    logic        a_nan, b_nan, a_inf, b_inf, sub, sticky, rnd;
    logic [5:0]  ex, ey, d;
    logic [13:0] mx, my, n;
    logic [14:0] sum;
    logic [6:0]  e;
    logic [11:0] mr;
    res    = '0;
    a_nan  = (op_a[14:10] == 5'h1F) && (op_a[9:0] != 10'd0);
    b_nan  = (op_b[14:10] == 5'h1F) && (op_b[9:0] != 10'd0);
    a_inf  = (op_a[14:10] == 5'h1F) && (op_a[9:0] == 10'd0);
    b_inf  = (op_b[14:10] == 5'h1F) && (op_b[9:0] == 10'd0);
    if (a_nan || b_nan || (a_inf && b_inf && (op_a[15] != op_b[15]))) begin
      res = 16'h7E00;
    end else if (a_inf) begin
      res = op_a;
    end else if (b_inf) begin
      res = op_b;
    end else begin
      if (op_a[14:0] >= op_b[14:0]) begin
        x = op_a;
        y = op_b;
      end else begin
        x = op_b;
        y = op_a;
      end
      // subnormals use an effective exponent of 1 and no hidden bit
      ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
      ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
      mx = {x[14:10] != 5'd0, x[9:0], 3'b000};
      my = {y[14:10] != 5'd0, y[9:0], 3'b000};
      d  = ex - ey;
      if (d > 6'd13) begin
        sticky = |my;
        my     = '0;
      end else begin
        sticky = |(my & ~(14'h3FFF << d));
        my     = my >> d;
      end
      my[0] = my[0] | sticky;
      sub   = x[15] ^ y[15];
      sum   = sub ? ({1'b0, mx} - {1'b0, my}) : ({1'b0, mx} + {1'b0, my});
      e     = {1'b0, ex};
      if (sum == 15'd0) begin
        // exact cancellation gives +0 unless both inputs were -0
        res = {x[15] & y[15], 15'd0};
      end else begin
        if (sum[14]) begin
          n = sum[14:1] | {13'd0, sum[0]};
          e = e + 7'd1;
        end else begin
          n = sum[13:0];
          for (int i = 0; i < 13; i++) begin
            if (!n[13] && (e > 7'd1)) begin
              n = n << 1;
              e = e - 7'd1;
            end
          end
        end
        if (!n[13]) e = 7'd0;
        rnd = n[2] & (n[1] | n[0] | n[3]);
        mr  = {1'b0, n[13:3]} + {11'd0, rnd};
        if (mr[11]) begin
          mr = mr >> 1;
          e  = e + 7'd1;
        end else if ((e == 7'd0) && mr[10]) begin
          // subnormal rounded up into the smallest normal
          e = 7'd1;
        end
        if (e >= 7'd31) res = {x[15], 5'h1F, 10'd0};
        else            res = {x[15], e[4:0], mr[9:0]};
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    res_pipe[0] <= fp16_add(a, b);
    vld_pipe[0] <= valid_in;
    for (int i = 1; i < LAT; i++) begin
      res_pipe[i] <= res_pipe[i-1];
      vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign result    = res_pipe[LAT-1];
  assign valid_out = vld_pipe[LAT-1];

endmodule

module hc_reduce #(
  parameter int DW      = 16,
  parameter int H_TILE  = 1,
  parameter int P_TILE  = 1,
  parameter int N_TILE  = 128,
  parameter int N_TILES = 1,
  parameter int A_LAT   = 11
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                valid_i,
  output logic                                ready_o,
  input  logic [H_TILE*P_TILE*N_TILE*DW-1:0]  hC_i,
  output logic [H_TILE*P_TILE*DW-1:0]         y_o,
  output logic                                valid_o
);

  localparam int LANES  = H_TILE * P_TILE;
  localparam int LEVELS = $clog2(N_TILE);
  localparam int NODES  = 2 * N_TILE - 1;
  localparam int CW     = (N_TILES > 1) ? $clog2(N_TILES) : 1;
  localparam logic [CW-1:0] LAST_TILE = CW'(N_TILES - 1);

  typedef enum logic [1:0] {IDLE, TREE, ACC} state_t;

  state_t                      state;
  logic [CW-1:0]               tile_cnt;
  logic [LANES*N_TILE*DW-1:0]  hc_q;
  logic                        tree_start;
  logic [DW-1:0]               acc [LANES];
  logic [DW-1:0]               acc_b [LANES];
  logic [DW-1:0]               acc_res [LANES];
  logic [LANES-1:0]            acc_vld;
  logic [LANES-1:0]            root_vld;
  logic                        tree_vld;
  logic                        acc_done;
  logic                        acc_launch;

  // Heap-style node storage per lane: leaves at 0..N_TILE-1, then each tree
  // level packed after the previous one, root at NODES-1.
  logic [DW-1:0]               node     [LANES][NODES];
  logic                        node_vld [LANES][NODES];

  // Every lane has the same latency, so the AND of the lane valids is the
  // lane-0 valid in practice while still consuming every lane's flag.
  assign tree_vld   = &root_vld;
  assign acc_done   = &acc_vld;
  assign acc_launch = (state == TREE) && tree_vld;
  assign ready_o    = (state == IDLE) && rstn;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    for (genvar n = 0; n < N_TILE; n++) begin : g_leaf
      assign node[l][n]     = hc_q[(l*N_TILE+n)*DW +: DW];
      assign node_vld[l][n] = tree_start;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int IN_OFF  = 2*N_TILE - 2*(N_TILE >> (k-1));
      localparam int OUT_OFF = 2*N_TILE - 2*(N_TILE >> k);
      for (genvar j = 0; j < (N_TILE >> k); j++) begin : g_node
        fp16_add_wrapper #(.LAT(A_LAT)) u_add (
          .clk       (clk),
          .valid_in  (node_vld[l][IN_OFF+2*j] & node_vld[l][IN_OFF+2*j+1]),
          .a         (node[l][IN_OFF+2*j]),
          .b         (node[l][IN_OFF+2*j+1]),
          .valid_out (node_vld[l][OUT_OFF+j]),
          .result    (node[l][OUT_OFF+j])
        );
      end
    end

    assign root_vld[l] = node_vld[l][NODES-1];

    // The first tile of a token starts from zero instead of the old sum.
    assign acc_b[l] = (tile_cnt == '0) ? '0 : acc[l];

    fp16_add_wrapper #(.LAT(A_LAT)) u_acc (
      .clk       (clk),
      .valid_in  (acc_launch),
      .a         (node[l][NODES-1]),
      .b         (acc_b[l]),
      .valid_out (acc_vld[l]),
      .result    (acc_res[l])
    );
  end

  // Control FSM plus all result registers. Adder valids that arrive outside
  // the state waiting for them (stale pipeline contents after a reset) are
  // simply not looked at.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      tile_cnt   <= '0;
      hc_q       <= '0;
      tree_start <= 1'b0;
      y_o        <= '0;
      valid_o    <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      valid_o    <= 1'b0;
      tree_start <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            hc_q       <= hC_i;
            tree_start <= 1'b1;
            state      <= TREE;
          end
        end
        TREE: begin
          if (tree_vld) state <= ACC;
        end
        ACC: begin
          if (acc_done) begin
            for (int l = 0; l < LANES; l++) acc[l] <= acc_res[l];
            if (tile_cnt == LAST_TILE) begin
              for (int l = 0; l < LANES; l++) y_o[l*DW +: DW] <= acc_res[l];
              valid_o  <= 1'b1;
              tile_cnt <= '0;
            end else begin
              tile_cnt <= tile_cnt + CW'(1);
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hc_reduce.sv
// -----------------------------------------------------------------------------
// tb_hc_reduce
//   Bench for hc_reduce with N_TILE=4. Instance dut_a has four lanes
//   (H_TILE=P_TILE=2) and N_TILES=1; instance dut_b has one lane and
//   N_TILES=2. Both share clock and reset.
// -----------------------------------------------------------------------------
module tb_hc_reduce;

  localparam int TOTAL_LAT = 3*11 + 2;

  logic         clk;
  logic         rstn;
  logic         valid_a, ready_a, vout_a;
  logic [255:0] hc_a;
  logic [63:0]  y_a;
  logic         valid_b, ready_b, vout_b;
  logic [63:0]  hc_b;
  logic [15:0]  y_b;

  int checks;
  int failures;

  hc_reduce #(.DW(16), .H_TILE(2), .P_TILE(2), .N_TILE(4), .N_TILES(1), .A_LAT(11)) dut_a (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_a),
    .ready_o (ready_a),
    .hC_i    (hc_a),
    .y_o     (y_a),
    .valid_o (vout_a)
  );

  hc_reduce #(.DW(16), .H_TILE(1), .P_TILE(1), .N_TILE(4), .N_TILES(2), .A_LAT(11)) dut_b (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_b),
    .ready_o (ready_b),
    .hC_i    (hc_b),
    .y_o     (y_b),
    .valid_o (vout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [255:0] hc;
    logic [63:0]  y;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Lanes given as {n3,n2,n1,n0}; lane 0 lands in the low bits.
  function automatic logic [255:0] packLanes(input logic [63:0] l0, input logic [63:0] l1,
                                             input logic [63:0] l2, input logic [63:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Send one tile to dut_a from a negedge and wait for its valid_o.
  task automatic applyStimulus(input logic [255:0] hc, output logic [63:0] y, output int lat,
                               output logic rdy_after);
    int guard;
    guard = 0;
    while (!ready_a && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    valid_a = 1'b1;
    hc_a    = hc;
    @(negedge clk);
    valid_a   = 1'b0;
    hc_a      = '0;
    rdy_after = ready_a;
    lat       = 1;
    while (!vout_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    y = y_a;
  endtask

  // Send one tile to dut_b and wait for ready_o to return, noting any valid_o.
  task automatic driveTileB(input logic [63:0] hc, output int rdy_lat, output int vld_lat,
                            output logic [15:0] y, output logic low_ok);
    int k;
    valid_b = 1'b1;
    hc_b    = hc;
    @(negedge clk);
    valid_b = 1'b0;
    hc_b    = '0;
    k       = 1;
    vld_lat = 0;
    low_ok  = 1'b1;
    while (!ready_b && k < 100) begin
      if (vout_b) vld_lat = k;
      @(negedge clk);
      k++;
    end
    if (vout_b) vld_lat = k;
    if (k != TOTAL_LAT) low_ok = 1'b0;
    rdy_lat = k;
    y       = y_b;
  endtask

  initial begin
    logic [63:0]  y;
    logic [15:0]  yb;
    logic [63:0]  y1, y2;
    logic         rdy_after, low_ok;
    int           lat, rdy_lat, vld_lat, phase, stray;
    logic [255:0] all1, all2;

    checks   = 0;
    failures = 0;
    all1     = {16{16'h3C00}};
    all2     = {16{16'h4000}};

    vecs[0] = '{"all_one", all1, {4{16'h4400}}};
    vecs[1] = '{"lane_pack",
                packLanes({4{16'h3C00}}, {4{16'h4000}}, {4{16'h4200}}, {4{16'h4400}}),
                {16'h4C00, 16'h4A00, 16'h4800, 16'h4400}};
    vecs[2] = '{"signs",
                packLanes({16'h3C00, 16'h3C00, 16'hC000, 16'h4000},
                          {16'h3800, 16'h3800, 16'hBC00, 16'h3C00},
                          {16'h0000, 16'h0000, 16'hC200, 16'h4400},
                          {16'hBC00, 16'h3C00, 16'h3C00, 16'h3C00}),
                {16'h4000, 16'h3C00, 16'h3C00, 16'h4000}};
    vecs[3] = '{"zeros", '0, 64'h0};
    vecs[4] = '{"boundary",
                packLanes({16'h0000, 16'h0000, 16'h7BFF, 16'h7BFF},
                          {16'h0000, 16'h0000, 16'h3C00, 16'h7C00},
                          {16'h0000, 16'h0000, 16'h0001, 16'h3C00},
                          {4{16'h0001}}),
                {16'h0004, 16'h3C00, 16'h7C00, 16'h7C00}};

    rstn    = 1'b0;
    valid_a = 1'b0;
    valid_b = 1'b0;
    hc_a    = '0;
    hc_b    = '0;

    // long reset also flushes whatever the unreset adder pipelines hold
    repeat (40) @(negedge clk);
    checkOutput("rst_ready_a", {63'd0, ready_a}, 64'd0);
    checkOutput("rst_ready_b", {63'd0, ready_b}, 64'd0);
    checkOutput("rst_valid_a", {63'd0, vout_a}, 64'd0);
    checkOutput("rst_y_a", y_a, 64'd0);
    checkOutput("rst_y_b", {48'd0, y_b}, 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready_a", {63'd0, ready_a}, 64'd1);
    checkOutput("post_rst_ready_b", {63'd0, ready_b}, 64'd1);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].hc, y, lat, rdy_after);
      checkOutput({vecs[i].name, "_busy"}, {63'd0, rdy_after}, 64'd0);
      checkOutput({vecs[i].name, "_lat"}, 64'(lat), 64'(TOTAL_LAT));
      checkOutput({vecs[i].name, "_y"}, y, vecs[i].y);
      @(negedge clk);
      checkOutput({vecs[i].name, "_pulse"}, {63'd0, vout_a}, 64'd0);
    end

    // valid_i held high with changing data: only ready cycles are sampled,
    // including the cycle in which valid_o and ready_o return together
    phase   = 0;
    y1      = '0;
    y2      = '0;
    valid_a = 1'b1;
    hc_a    = all1;
    for (int i = 0; i < 200 && phase < 2; i++) begin
      @(negedge clk);
      if (vout_a) begin
        phase++;
        if (phase == 1) y1 = y_a;
        else            y2 = y_a;
      end
      if (phase == 2)              valid_a = 1'b0;
      else if (ready_a)            hc_a = all2;
      else                         hc_a = {16{16'(16'h5A00 + i)}};
    end
    valid_a = 1'b0;
    checkOutput("hs_tokens", 64'(phase), 64'd2);
    checkOutput("hs_first_y", y1, {4{16'h4400}});
    checkOutput("hs_second_y", y2, {4{16'h4800}});

    // two-tile accumulation on dut_b
    @(negedge clk);
    driveTileB({4{16'h3C00}}, rdy_lat, vld_lat, yb, low_ok);
    checkOutput("acc_t0_ready_lat", 64'(rdy_lat), 64'(TOTAL_LAT));
    checkOutput("acc_t0_no_valid", 64'(vld_lat), 64'd0);
    driveTileB({4{16'h3800}}, rdy_lat, vld_lat, yb, low_ok);
    checkOutput("acc_t1_busy", {63'd0, low_ok}, 64'd1);
    checkOutput("acc_t1_valid_lat", 64'(vld_lat), 64'(TOTAL_LAT));
    checkOutput("acc_t1_y", {48'd0, yb}, 64'h4600);
    stray = 0;
    repeat (10) begin
      @(negedge clk);
      if (vout_b) stray++;
    end
    checkOutput("hold_no_pulse", 64'(stray), 64'd0);
    checkOutput("hold_y", {48'd0, y_b}, 64'h4600);

    // reset pulse while tile 1 sits in the accumulator adder
    driveTileB({4{16'h3C00}}, rdy_lat, vld_lat, yb, low_ok);
    valid_b = 1'b1;
    hc_b    = {4{16'h3C00}};
    @(negedge clk);
    valid_b = 1'b0;
    repeat (26) @(negedge clk);
    rstn = 1'b0;
    #1;
    checkOutput("midrst_ready_low", {63'd0, ready_b}, 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("midrst_ready_high", {63'd0, ready_b}, 64'd1);
    checkOutput("midrst_y_cleared", {48'd0, y_b}, 64'd0);
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (vout_b) stray++;
    end
    checkOutput("midrst_no_valid", 64'(stray), 64'd0);

    driveTileB({4{16'h3C00}}, rdy_lat, vld_lat, yb, low_ok);
    checkOutput("fresh_t0_no_valid", 64'(vld_lat), 64'd0);
    driveTileB({4{16'h3C00}}, rdy_lat, vld_lat, yb, low_ok);
    checkOutput("fresh_t1_valid_lat", 64'(vld_lat), 64'(TOTAL_LAT));
    checkOutput("fresh_t1_y", {48'd0, yb}, 64'h4800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hc_reduce.md
# hC_reduce

Reduction stage directly downstream of the per-lane hC multiplier. It sums hC(h,p,n) over the state dimension n to produce y(h,p) = Σ_n hnext(h,p,n)·C(n) for every (h,p) lane in the tile. Each N_TILE-wide slice is reduced with a pipelined FP16 adder tree, and the slice sums are accumulated across N_TILES consecutive tiles. One y vector is emitted per token.

## Interface
- DW, 16, element width (FP16)
- H_TILE, 1, heads per tile
- P_TILE, 1, head-dim lanes per tile
- N_TILE, 128, state elements per input tile; power of two, ≥ 2
- N_TILES, 1, input tiles per token (full N = N_TILE·N_TILES); ≥ 1
- A_LAT, 11, latency of fp16_add_wrapper; must match the wrapper

Ports:
- clk  in  1  clock
- rstn  in  1  reset; rstn, synchronous, active-low; clock clk
- valid_i  in  1  tile valid; accepted only when ready_o=1
- ready_o  out  1  block can accept a tile
- hC_i  in  H_TILE·P_TILE·N_TILE·DW  products; element index ((h·P_TILE+p)·N_TILE+n)
- y_o  out  H_TILE·P_TILE·DW  token result; element index (h·P_TILE+p)
- valid_o  out  1  one-cycle pulse, y_o valid

## Operation
- **Accept:** a tile is accepted when valid_i & ready_o. While ready_o=0, valid_i is ignored; it is not an error.
- **Tree:** for each (h,p) lane, a binary tree of fp16_add_wrapper instances with log2(N_TILE) levels. Level k adds adjacent pairs (2j, 2j+1) of level k-1 outputs. TREE_LAT = log2(N_TILE)·A_LAT.
- **Accumulator:**
  - One fp16_add_wrapper per lane; operand a = tree output, operand b = acc register.
  - b is forced to 16'h0000 when tile_cnt==0.
  - The result is written into acc on the adder's valid_out.
- **tile_cnt:** counts 0..N_TILES-1. It increments when the accumulator result is captured and wraps to 0 after the last tile.
- **FSM:** states IDLE, TREE, ACC.
  - IDLE: ready_o=1. On accept → TREE.
  - TREE: ready_o=0. On lane-0 tree valid_out → ACC, launching the accumulator add.
  - ACC: ready_o=0. On lane-0 accumulator valid_out:
    - capture acc;
    - if tile_cnt==N_TILES-1: load y_o ← result, pulse valid_o, tile_cnt←0;
    - otherwise tile_cnt++;
    - then → IDLE.
- **Stale valids:** all lanes have identical latency, so lane 0 valid_out stands for every lane. Wrapper valid_outs arriving in a state that does not expect them are ignored. This covers stale pipeline contents after reset, because the wrappers have no reset.
- **Arithmetic:** plain FP16 with wrapper rounding.
  - Summation order is fixed: pairwise tree inside a tile, then tiles in arrival order.
  - No saturation logic; inf/NaN propagate per the wrapper.

## Timing
- **Reset (rstn=0 at a clk edge):**
  - state←IDLE, tile_cnt←0, acc←0, y_o←0, valid_o←0.
  - ready_o=0 while rstn is low; ready_o=1 from the first cycle after rstn rises.
- **Reset mid-operation:** any partial accumulation is discarded and no valid_o is produced for that token. The next accepted tile is treated as tile 0.
- **Per-tile latency:** accept at cycle t; accumulator result captured at t+TREE_LAT+A_LAT+1; ready_o high again the following cycle.
  - Minimum tile spacing is TREE_LAT+A_LAT+2 cycles.
- **Output timing:** valid_o is high for exactly one cycle, at capture+1 of the last tile, i.e. t_last+TREE_LAT+A_LAT+2.
- **y_o hold:** y_o holds its value until the next token's valid_o, and stays 0 until the first one.
- **N_TILES=1:** every accepted tile produces a valid_o.
- **valid_o vs ready_o:** for the last tile, valid_o and the return of ready_o occur in the same cycle. An accept in that cycle starts tile 0 of the next token.

## Test plan
All cases use N_TILE=4, H_TILE=P_TILE=1 unless stated.
- **Single tile:** N_TILES=1; all hC=0x3C00 (1.0), one accept → y_o=0x4400 (4.0). valid_o exactly 2·A_LAT+A_LAT+2 cycles after accept, one cycle wide.
- **Two-tile accumulation:** N_TILES=2.
  - Tile0 all 0x3C00 → no valid_o.
  - Tile1 all 0x3800 (0.5) → y_o=0x4600 (6.0).
  - ready_o low for the full in-flight window of each tile.
- **Handshake ignore:** hold valid_i=1 continuously with changing data → only tiles sampled while ready_o=1 contribute. Data on valid_i cycles while ready_o=0 has no effect on y_o.
- **Signs and order:** N_TILES=1; tile {0x4000, 0xC000, 0x3C00, 0x3C00} (2, −2, 1, 1) → 0x4000. Then a second token with all lanes 0x0000 → y_o=0x0000, confirming acc is cleared at tile 0.
- **Multi-lane packing:** H_TILE=2, P_TILE=2; lane k all = k+1.0 → y_o lanes = 4.0, 8.0, 12.0, 16.0 (0x4400, 0x4800, 0x4A00, 0x4C00) in index order.
- **Reset mid-token:** N_TILES=2; assert rstn=0 for one cycle during the ACC state of tile1.
  - No valid_o; ready_o=0 during reset, 1 the cycle after.
  - A fresh 2-tile token of all 1.0 then yields y_o=0x4800 (8.0) with no contamination.
